// File: rtl/nf_10g_tx_store_forward.sv
// nf_10g_tx_store_forward
//   Store-and-forward AXI4-Stream packet buffer for the 10G transmit path.
//   A packet is only offered downstream once its last beat is stored, so the
//   MAC never sees a tvalid bubble inside a frame. Packets longer than the
//   data buffer are discarded whole and counted.
// Ports
//   axis_aclk / axis_reset : single clock, async active-high reset
//   s_axis_*               : upstream stream (host/DMA)
//   m_axis_*               : downstream stream (10G interface s_axis)
//   pkt_count              : committed packets not yet fully sent
//   drop_count             : oversize packets dropped (wraps)
module nf_10g_tx_store_forward #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH_LOG2       = 7,
  parameter int C_MAX_PKTS_LOG2    = 4
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [C_MAX_PKTS_LOG2:0]        pkt_count,
  output logic [31:0]                     drop_count
);

  localparam int DW    = C_AXIS_DATA_WIDTH;
  localparam int KW    = C_AXIS_DATA_WIDTH / 8;
  localparam int UW    = C_AXIS_TUSER_WIDTH;
  localparam int AW    = C_DEPTH_LOG2;
  localparam int PW    = C_MAX_PKTS_LOG2;
  localparam int EW    = DW + KW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int NPKT  = 1 << PW;
  localparam logic [AW:0] DATA_FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [PW:0] DESC_FULL_CNT = {1'b1, {PW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_STORE, S_DROP} wr_state_e;

  wr_state_e       state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     wr_commit_q, wr_commit_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]     rd_limit_q, rd_limit_d;   // commit point as seen by the reader
  logic [PW:0]     desc_wr_q, desc_wr_d;
  logic [PW:0]     desc_rd_q, desc_rd_d;     // popped on accepted output tlast
  logic [PW:0]     desc_ld_q, desc_ld_d;     // packet currently being prefetched
  logic [UW-1:0]   tuser_lat_q, tuser_lat_d;
  logic [31:0]     drop_cnt_q, drop_cnt_d;
  logic            rdy_en_q;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [KW-1:0]   m_keep_q, m_keep_d;
  logic [UW-1:0]   m_user_q, m_user_d;
  logic            m_last_q, m_last_d;
  logic            m_valid_q, m_valid_d;

  logic [EW-1:0]   data_mem [DEPTH];
  logic [UW-1:0]   desc_mem [NPKT];

  logic            mem_we, desc_we;
  logic [UW-1:0]   desc_wdata;
  logic            data_full, desc_full, s_acc;
  logic [AW:0]     len_next;
  logic [EW-1:0]   rd_entry;
  logic            data_avail, load, out_pop;

  assign data_full     = (wr_ptr_q - rd_ptr_q) == DATA_FULL_CNT;
  assign desc_full     = (desc_wr_q - desc_rd_q) == DESC_FULL_CNT;
  // DROP swallows the rest of an oversize packet regardless of buffer state.
  assign s_axis_tready = rdy_en_q && ((state_q == S_DROP) || (!data_full && !desc_full));
  assign s_acc         = s_axis_tvalid && s_axis_tready;
  assign len_next      = wr_ptr_q + 1'b1 - wr_commit_q;

  assign rd_entry      = data_mem[rd_ptr_q[AW-1:0]];
  assign data_avail    = rd_ptr_q != rd_limit_q;
  assign out_pop       = m_valid_q && m_axis_tready;
  // Only whole committed packets are visible, so once a packet starts the
  // prefetch never runs dry before its tlast.
  assign load          = data_avail && (!m_valid_q || m_axis_tready);

  // Write side FSM
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    desc_wr_d   = desc_wr_q;
    tuser_lat_d = tuser_lat_q;
    drop_cnt_d  = drop_cnt_q;
    mem_we      = 1'b0;
    desc_we     = 1'b0;
    desc_wdata  = tuser_lat_q;
    unique case (state_q)
      S_IDLE, S_STORE: begin
        if (s_acc) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (state_q == S_IDLE) begin
            tuser_lat_d = s_axis_tuser;
            desc_wdata  = s_axis_tuser;
          end
          if (s_axis_tlast) begin
            wr_commit_d = wr_ptr_q + 1'b1;
            desc_we     = 1'b1;
            desc_wr_d   = desc_wr_q + 1'b1;
            state_d     = S_IDLE;
          end else if (len_next == DATA_FULL_CNT) begin
            // Packet cannot fit: discard what was stored and skip the rest.
            mem_we   = 1'b0;
            wr_ptr_d = wr_commit_q;
            state_d  = S_DROP;
          end else begin
            state_d = S_STORE;
          end
        end
      end
      S_DROP: begin
        if (s_acc && s_axis_tlast) begin
          drop_cnt_d = drop_cnt_q + 32'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read side: output register acting as FWFT prefetch stage
  always_comb begin
    rd_limit_d = wr_commit_q;
    rd_ptr_d   = rd_ptr_q;
    desc_rd_d  = desc_rd_q;
    desc_ld_d  = desc_ld_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    m_valid_d  = m_valid_q;
    if (load) begin
      m_data_d  = rd_entry[EW-1 -: DW];
      m_keep_d  = rd_entry[KW:1];
      m_last_d  = rd_entry[0];
      m_user_d  = desc_mem[desc_ld_q[PW-1:0]];
      m_valid_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + 1'b1;
      if (rd_entry[0]) desc_ld_d = desc_ld_q + 1'b1;
    end else if (out_pop) begin
      m_valid_d = 1'b0;
    end
    if (out_pop && m_last_q) desc_rd_d = desc_rd_q + 1'b1;
  end

  always_ff @(posedge axis_aclk) begin
    if (mem_we)  data_mem[wr_ptr_q[AW-1:0]]  <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    if (desc_we) desc_mem[desc_wr_q[PW-1:0]] <= desc_wdata;
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      rd_limit_q  <= '0;
      desc_wr_q   <= '0;
      desc_rd_q   <= '0;
      desc_ld_q   <= '0;
      tuser_lat_q <= '0;
      drop_cnt_q  <= '0;
      rdy_en_q    <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      m_user_q    <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_limit_q  <= rd_limit_d;
      desc_wr_q   <= desc_wr_d;
      desc_rd_q   <= desc_rd_d;
      desc_ld_q   <= desc_ld_d;
      tuser_lat_q <= tuser_lat_d;
      drop_cnt_q  <= drop_cnt_d;
      rdy_en_q    <= 1'b1;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;
  // Outstanding descriptors are exactly the committed, not-yet-sent packets.
  assign pkt_count     = desc_wr_q - desc_rd_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_nf_10g_tx_store_forward.sv
// Directed bench for nf_10g_tx_store_forward: drives packets on s_axis,
// collects accepted m_axis beats and compares them with the sent sequence.
module tb_nf_10g_tx_store_forward;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b1;
  logic [4:0]    pkt_count;
  logic [31:0]   drop_count;

  int errors = 0, checks = 0, cyc = 0, gap_err = 0, stab_err = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
    int            c;
  } beat_t;
  beat_t outq[$];
  beat_t expq[$];

  logic                 in_pkt = 1'b0, prev_stall = 1'b0;
  logic [DW+KW+UW+1:0]  prev_vec = '0;

  nf_10g_tx_store_forward dut (
    .axis_aclk(clk), .axis_reset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1 time unit after posedge; at negedge everything is settled
  // and reflects what the next posedge will see.
  always @(negedge clk) begin
    if (rst) begin
      in_pkt     <= 1'b0;
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser} !== prev_vec))
        stab_err <= stab_err + 1;
      if (in_pkt && !m_tvalid) gap_err <= gap_err + 1;
      prev_stall <= m_tvalid && !m_tready;
      prev_vec   <= {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser};
      if (m_tvalid && m_tready) begin
        outq.push_back(beat_t'{d: m_tdata, k: m_tkeep, l: m_tlast, u: m_tuser, c: cyc});
        in_pkt <= !m_tlast;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mkd(input int p, input int b);
    logic [31:0] a, c;
    a = p;
    c = b;
    return {a, c, ~a, ~c, a ^ 32'h5A5A5A5A, c + 32'h1000, a + c, 32'hC0DE0000 ^ c};
  endfunction

  // Number of beats that differ between collected and expected sequences.
  function automatic int seq_mm();
    int mm = 0;
    int n = (outq.size() < expq.size()) ? outq.size() : expq.size();
    mm = (outq.size() > expq.size()) ? outq.size() - expq.size() : expq.size() - outq.size();
    for (int i = 0; i < n; i++)
      if (outq[i].d !== expq[i].d || outq[i].k !== expq[i].k ||
          outq[i].l !== expq[i].l || outq[i].u !== expq[i].u) mm++;
    return mm;
  endfunction

  // Entered and left at posedge+1. Non-first beats carry ~u on tuser so a
  // design that forwards per-beat tuser is caught.
  task automatic send_pkt(input int p, input int n, input logic [UW-1:0] u, input int stall,
                          input bit expect_out, input logic [KW-1:0] last_keep, input bit with_last);
    int w;
    for (int b = 0; b < n; b++) begin
      if (stall > 0)
        while ($urandom_range(0, 99) < stall) begin
          s_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      s_tdata  = mkd(p, b);
      s_tkeep  = (b == n - 1) ? last_keep : '1;
      s_tlast  = with_last && (b == n - 1);
      s_tuser  = (b == 0) ? u : ~u;
      s_tvalid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!s_tready && w < 3000) begin
        @(negedge clk);
        w++;
      end
      if (!s_tready) begin
        checks++; errors++;
        $display("FAIL send_timeout pkt=%0d beat=%0d tready=%0b required=1", p, b, s_tready);
        s_tvalid = 1'b0;
        return;
      end
      if (expect_out) expq.push_back(beat_t'{d: s_tdata, k: s_tkeep, l: s_tlast, u: u, c: 0});
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_out(input int cap, input string name);
    int w = 0;
    while (outq.size() < expq.size() && w < cap) begin
      @(posedge clk);
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
    if (outq.size() < expq.size()) begin
      checks++; errors++;
      $display("FAIL %s_timeout beats=%0d required=%0d", name, outq.size(), expq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_tready = 1'b1;
    #12;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got=%0b exp=0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got=%0b exp=0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast got=%0b exp=0", m_tlast); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rst_m_tdata got=%h exp=0", m_tdata); end
    checks++; if (m_tkeep !== '0) begin errors++; $display("FAIL rst_m_tkeep got=%h exp=0", m_tkeep); end
    checks++; if (m_tuser !== '0) begin errors++; $display("FAIL rst_m_tuser got=%h exp=0", m_tuser); end
    checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL rst_pkt_count got=%0d exp=0", pkt_count); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL rst_drop_count got=%0d exp=0", drop_count); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_rel_tready_early got=%0b exp=0", s_tready); end
    @(posedge clk); #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_rel_tready got=%0b exp=1", s_tready); end
  endtask

  task automatic test_single();
    outq.delete(); expq.delete();
    m_tready = 1'b1;
    send_pkt(1, 2, 128'h0001_0040, 0, 1, '1, 1);
    checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL single_pkt_count_commit got=%0d exp=1", pkt_count); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_tvalid_t0 got=%0b exp=0", m_tvalid); end
    @(posedge clk); #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_tvalid_t1 got=%0b exp=0", m_tvalid); end
    @(posedge clk); #1;
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid_t2 got=%0b exp=1", m_tvalid); end
    checks++; if (m_tuser !== 128'h0001_0040) begin errors++; $display("FAIL single_tuser got=%h exp=10040", m_tuser); end
    wait_out(50, "single");
    checks++; if (seq_mm() !== 0) begin errors++; $display("FAIL single_data mismatched_beats=%0d exp=0", seq_mm()); end
    checks++; if (outq.size() == 2 && outq[1].c - outq[0].c !== 1) begin errors++; $display("FAIL single_contig gap=%0d exp=1", outq[1].c - outq[0].c); end
    checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL single_pkt_count_end got=%0d exp=0", pkt_count); end
  endtask

  task automatic test_desc_full();
    outq.delete(); expq.delete();
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) send_pkt(100 + i, 1, 128'hD000 + i, 0, 1, 32'h0000_00FF, 1);
    checks++; if (pkt_count !== 5'd16) begin errors++; $display("FAIL dfull_pkt_count got=%0d exp=16", pkt_count); end
    @(negedge clk);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL dfull_tready got=%0b exp=0", s_tready); end
    @(posedge clk); #1;
    fork
      send_pkt(116, 1, 128'hD010, 0, 1, 32'h0000_00FF, 1);
      begin
        repeat (3) @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    wait_out(200, "dfull");
    checks++; if (seq_mm() !== 0) begin errors++; $display("FAIL dfull_order mismatched_beats=%0d exp=0", seq_mm()); end
    checks++;
    if (outq.size() != 17 || outq[16].c - outq[0].c !== 16) begin
      errors++;
      $display("FAIL dfull_no_gaps beats=%0d span=%0d exp=17/16", outq.size(),
               (outq.size() == 17) ? outq[16].c - outq[0].c : -1);
    end
    checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL dfull_pkt_count_end got=%0d exp=0", pkt_count); end
  endtask

  task automatic test_backpressure();
    int g0 = gap_err, s0 = stab_err;
    outq.delete(); expq.delete();
    m_tready = 1'b0;
    fork
      send_pkt(200, 10, 128'hBEEF_0010, 0, 1, 32'h0000_FFFF, 1);
      begin
        int w = 0;
        while (outq.size() < 10 && w < 400) begin
          @(posedge clk); #1;
          m_tready = ~m_tready;
          w++;
        end
        m_tready = 1'b1;
      end
    join
    wait_out(100, "bp");
    checks++; if (seq_mm() !== 0) begin errors++; $display("FAIL bp_data mismatched_beats=%0d exp=0", seq_mm()); end
    checks++; if (stab_err - s0 !== 0) begin errors++; $display("FAIL bp_stable changes=%0d exp=0", stab_err - s0); end
    checks++; if (gap_err - g0 !== 0) begin errors++; $display("FAIL bp_tvalid_gap gaps=%0d exp=0", gap_err - g0); end
  endtask

  task automatic test_wrap();
    int g0 = gap_err, s0 = stab_err;
    bit sdone = 1'b0;
    outq.delete(); expq.delete();
    fork
      begin
        for (int i = 0; i < 200; i++)
          send_pkt(1000 + i, $urandom_range(1, 128), {$urandom, $urandom, $urandom, $urandom},
                   25, 1, $urandom | 32'h1, 1);
        sdone = 1'b1;
      end
      begin
        int w = 0;
        while (!(sdone && outq.size() >= expq.size()) && w < 60000) begin
          @(posedge clk); #1;
          m_tready = ($urandom_range(0, 99) < 70);
          w++;
        end
        m_tready = 1'b1;
      end
    join
    wait_out(500, "wrap");
    checks++; if (seq_mm() !== 0) begin errors++; $display("FAIL wrap_seq mismatched_beats=%0d exp=0", seq_mm()); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL wrap_drop_count got=%0d exp=0", drop_count); end
    checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL wrap_pkt_count got=%0d exp=0", pkt_count); end
    checks++; if (gap_err - g0 !== 0) begin errors++; $display("FAIL wrap_tvalid_gap gaps=%0d exp=0", gap_err - g0); end
    checks++; if (stab_err - s0 !== 0) begin errors++; $display("FAIL wrap_stable changes=%0d exp=0", stab_err - s0); end
  endtask

  task automatic test_oversize();
    outq.delete(); expq.delete();
    m_tready = 1'b1;
    send_pkt(300, 129, 128'h0BAD, 0, 0, '1, 1);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL over_drop_count got=%0d exp=1", drop_count); end
    checks++; if (outq.size() !== 0) begin errors++; $display("FAIL over_no_output beats=%0d exp=0", outq.size()); end
    checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL over_pkt_count got=%0d exp=0", pkt_count); end
    send_pkt(301, 3, 128'h0003_00C0, 0, 1, 32'h0000_000F, 1);
    wait_out(50, "over");
    checks++; if (seq_mm() !== 0) begin errors++; $display("FAIL over_follow_data mismatched_beats=%0d exp=0", seq_mm()); end
    checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL over_drop_count_after got=%0d exp=1", drop_count); end
  endtask

  task automatic test_reset_mid();
    outq.delete(); expq.delete();
    m_tready = 1'b0;
    send_pkt(400, 4, 128'h4444, 0, 0, '1, 1);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_pre_tvalid got=%0b exp=1", m_tvalid); end
    send_pkt(401, 2, 128'h5555, 0, 0, '1, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid got=%0b exp=0", m_tvalid); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rmid_tdata got=%h exp=0", m_tdata); end
    checks++; if (m_tuser !== '0) begin errors++; $display("FAIL rmid_tuser got=%h exp=0", m_tuser); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rmid_s_tready got=%0b exp=0", s_tready); end
    checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL rmid_pkt_count got=%0d exp=0", pkt_count); end
    @(negedge clk);
    rst = 1'b0;
    m_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL rmid_pkt_count_post got=%0d exp=0", pkt_count); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_stale_tvalid got=%0b exp=0", m_tvalid); end
    outq.delete(); expq.delete();
    send_pkt(402, 2, 128'h0002_0040, 0, 1, 32'h00FF_FFFF, 1);
    wait_out(50, "rmid");
    checks++; if (seq_mm() !== 0) begin errors++; $display("FAIL rmid_fresh_data mismatched_beats=%0d exp=0", seq_mm()); end
    checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL rmid_pkt_count_end got=%0d exp=0", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_desc_full();
    test_backpressure();
    test_wrap();
    test_oversize();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
